vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Raster timing source for the 640x480@60 display. Produces HCounter/VCounter, the scan
//  position that every sprite/pixel block (meteor, defense bar, ship) compares against
//  to produce its per-pixel result. Also drives the VGA sync pins and frame/line strobes.
//  Counter origin is the leading edge of the sync pulse:
//    H: sync 0..95, back porch 96..143, visible 144..783, front porch 784..799.
//    V: sync 0..1, back porch 2..34, visible 35..514, front porch 515..524.
// PARAMETERS
//  H_VISIBLE  640  active pixels per line
//  H_FRONT    16   horizontal front porch, pixels
//  H_SYNC     96   hsync pulse width, pixels
//  H_BACK     48   horizontal back porch, pixels
//  V_VISIBLE  480  active lines per frame
//  V_FRONT    10   vertical front porch, lines
//  V_SYNC     2    vsync pulse width, lines
//  V_BACK     33   vertical back porch, lines
//  SYNC_POL   0    active level of hsync/vsync (0 = active-low)
//  Constraint: H_TOTAL = sum of H_* <= 1024; V_TOTAL = sum of V_* <= 1024.
// PORTS
//  clk         in   1   system clock; pixel clock unless CLK_DIV2_EN is defined
//  resetn      in   1   asynchronous reset, active-low
//  HCounter    out  10  horizontal position, 0..H_TOTAL-1
//  VCounter    out  10  vertical position, 0..V_TOTAL-1
//  hsync       out  1   horizontal sync, level per SYNC_POL
//  vsync       out  1   vertical sync, level per SYNC_POL
//  video_on    out  1   1 while (HCounter,VCounter) is in the visible window
//  pix_stb     out  1   1 on cycles where the counters advance
//  line_tick   out  1   one-clk pulse, coincident with HCounter becoming 0
//  frame_tick  out  1   one-clk pulse, coincident with (HCounter,VCounter) becoming (0,0)
// BEHAVIOUR
//  - Reset (async assert, sync release): HCounter=0, VCounter=0, hsync=vsync=SYNC_POL,
//    video_on=0, line_tick=0, frame_tick=0, pix_stb=0 (CLK_DIV2_EN) or 1 (without).
//  - Advance on a pix_stb cycle:
//    HCounter++, wrapping H_TOTAL-1 -> 0. On that wrap VCounter++, wrapping V_TOTAL-1 -> 0.
//    Counters hold on non-strobe cycles. No other wrap point exists.
//  - All outputs are registered and computed from next-state counter values, so hsync,
//    vsync and video_on describe the counter values visible in the same cycle
//    (zero relative latency).
//  - hsync = SYNC_POL when HCounter < H_SYNC, else ~SYNC_POL.
//  - vsync = SYNC_POL when VCounter < V_SYNC, else ~SYNC_POL.
//  - video_on = 1 when both hold:
//      H_SYNC+H_BACK <= HCounter < H_SYNC+H_BACK+H_VISIBLE
//      V_SYNC+V_BACK <= VCounter < V_SYNC+V_BACK+V_VISIBLE
//  - line_tick/frame_tick are exactly one clk wide, even when pix_stb is divided.
//    They are 0 on every other cycle.
//  - frame_tick implies line_tick in the same cycle.
//  - No reset-to-zero transition generates a tick: first frame_tick appears after a full frame.
//  - Reset asserted mid-frame: all state returns to reset values immediately.
//    The frame restarts from (0,0) after release.
// CONFIGURATION
//  CLK_DIV2_EN defined:
//    clk is 50 MHz; an internal toggle flop drives pix_stb 0,1,0,1... starting 0 after reset.
//    Counters advance on cycles with pix_stb=1. Frame = 840000 clk.
//  CLK_DIV2_EN undefined:
//    pix_stb tied 1 (after reset); counters advance every clk. Frame = 420000 clk.
// TESTING
//  1. Release reset, no macro -> HCounter 0..799 then 0, VCounter increments 0->1 at clk 800, line_tick at clk 800.
//  2. Run 420000 clk -> frame_tick single pulse at counters (0,0); next frame_tick exactly 420000 clk later.
//  3. Scan sync: hsync low for HCounter 0..95 only, vsync low for VCounter 0..1 only.
//  4. video_on: 0 at (143,35), 1 at (144,35), 1 at (783,514), 0 at (784,514), 0 at (144,515).
//  5. CLK_DIV2_EN: counter changes every 2 clk, frame_tick period 840000 clk, tick width 1 clk.
//  6. Assert resetn at (400,300) for 3 clk -> outputs at reset values asynchronously; restart from (0,0).

Source files
------------

// File: rtl/vga_timing_gen.sv
// Raster timing source for the 640x480@60 display: scan counters, sync pins, visible window and line/frame strobes.
// Define CLK_DIV2_EN when clk runs at twice the pixel rate; the counters then advance on every other clk.
module vga_timing_gen #(
  parameter int   H_VISIBLE = 640,
  parameter int   H_FRONT   = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BACK    = 48,
  parameter int   V_VISIBLE = 480,
  parameter int   V_FRONT   = 10,
  parameter int   V_SYNC    = 2,
  parameter int   V_BACK    = 33,
  parameter logic SYNC_POL  = 1'b0
) (
  input  logic       clk,
  input  logic       resetn,
  output logic [9:0] HCounter,
  output logic [9:0] VCounter,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       pix_stb,
  output logic       line_tick,
  output logic       frame_tick
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SYNC_END  = 10'(H_SYNC);
  localparam logic [9:0] V_SYNC_END  = 10'(V_SYNC);
  localparam logic [9:0] H_VIS_START = 10'(H_SYNC + H_BACK);
  localparam logic [9:0] H_VIS_END   = 10'(H_SYNC + H_BACK + H_VISIBLE);
  localparam logic [9:0] V_VIS_START = 10'(V_SYNC + V_BACK);
  localparam logic [9:0] V_VIS_END   = 10'(V_SYNC + V_BACK + V_VISIBLE);

`ifdef CLK_DIV2_EN
  localparam logic STB_RESET = 1'b0;
`else
  localparam logic STB_RESET = 1'b1;
`endif

  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;
  logic       stb_q, stb_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       video_q, video_d;
  logic       line_q, line_d;
  logic       frame_q, frame_d;

  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    h_d     = h_q;
    v_d     = v_q;
    line_d  = 1'b0;
    frame_d = 1'b0;
`ifdef CLK_DIV2_EN
    stb_d   = ~stb_q;
`else
    stb_d   = 1'b1;
`endif

    if (stb_q) begin
      if (h_q == H_LAST) begin
        h_d    = '0;
        line_d = 1'b1;
        if (v_q == V_LAST) begin
          v_d     = '0;
          frame_d = 1'b1;
        end else begin
          v_d = v_q + 10'd1;
        end
      end else begin
        h_d = h_q + 10'd1;
      end
    end

    // Decoded from the next-state counters so the registered flags line up with the counters they describe.
    hsync_d = (h_d < H_SYNC_END) ? SYNC_POL : ~SYNC_POL;
    vsync_d = (v_d < V_SYNC_END) ? SYNC_POL : ~SYNC_POL;
    video_d = (h_d >= H_VIS_START) && (h_d < H_VIS_END) &&
              (v_d >= V_VIS_START) && (v_d < V_VIS_END);
  end

  // NOTE: sequential state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      h_q     <= '0;
      v_q     <= '0;
      stb_q   <= STB_RESET;
      hsync_q <= SYNC_POL;
      vsync_q <= SYNC_POL;
      video_q <= 1'b0;
      line_q  <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      stb_q   <= stb_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      video_q <= video_d;
      line_q  <= line_d;
      frame_q <= frame_d;
    end
  end

  assign HCounter   = h_q;
  assign VCounter   = v_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign video_on   = video_q;
  assign pix_stb    = stb_q;
  assign line_tick  = line_q;
  assign frame_tick = frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: a full-size 640x480 instance and a shrunken-raster instance
// (opposite sync polarity) checked against a cycle-count arithmetic model of the raster.
module tb_vga_timing_gen;

`ifdef CLK_DIV2_EN
  localparam int DIV = 2;
`else
  localparam int DIV = 1;
`endif

  localparam int S_HV = 8, S_HF = 2, S_HS = 3, S_HB = 2;
  localparam int S_VV = 4, S_VF = 1, S_VS = 2, S_VB = 1;
  localparam int S_FRAME = (S_HV + S_HF + S_HS + S_HB) * (S_VV + S_VF + S_VS + S_VB);

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic [9:0] hc_a, vc_a, hc_b, vc_b;
  logic hs_a, vs_a, vid_a, stb_a, lt_a, ft_a;
  logic hs_b, vs_b, vid_b, stb_b, lt_b, ft_b;

  vga_timing_gen dut_a (
    .clk(clk), .resetn(resetn), .HCounter(hc_a), .VCounter(vc_a),
    .hsync(hs_a), .vsync(vs_a), .video_on(vid_a), .pix_stb(stb_a),
    .line_tick(lt_a), .frame_tick(ft_a)
  );

  vga_timing_gen #(
    .H_VISIBLE(S_HV), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
    .V_VISIBLE(S_VV), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB),
    .SYNC_POL(1'b1)
  ) dut_b (
    .clk(clk), .resetn(resetn), .HCounter(hc_b), .VCounter(vc_b),
    .hsync(hs_b), .vsync(vs_b), .video_on(vid_b), .pix_stb(stb_b),
    .line_tick(lt_b), .frame_tick(ft_b)
  );

  int n;            // clk edges since reset release
  int passed = 0;
  int failed = 0;
  int total  = 0;
  int last_ft_b = -1;

  // Expected outputs after n clk edges since release: {H, V, hsync, vsync, video_on, pix_stb, line_tick, frame_tick}.
  function automatic logic [25:0] model(int cyc, int hv, int hf, int hs, int hb,
                                        int vv, int vf, int vs, int vb, logic pol);
    int ht, vt, pos, h, v;
    logic stepped, lt, ft, pix, hsy, vsy, vid;
    ht  = hv + hf + hs + hb;
    vt  = vv + vf + vs + vb;
    pos = cyc / DIV;
    h   = pos % ht;
    v   = (pos / ht) % vt;
    stepped = (cyc > 0) && (cyc % DIV == 0);
    lt  = stepped && (h == 0);
    ft  = lt && (v == 0);
    pix = (DIV == 1) ? 1'b1 : logic'(cyc % 2);
    hsy = (h < hs) ? pol : ~pol;
    vsy = (v < vs) ? pol : ~pol;
    vid = (h >= hs + hb) && (h < hs + hb + hv) && (v >= vs + vb) && (v < vs + vb + vv);
    return {10'(h), 10'(v), hsy, vsy, vid, pix, lt, ft};
  endfunction

  function automatic logic [25:0] exp_a(int cyc);
    return model(cyc, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0);
  endfunction

  function automatic logic [25:0] exp_b(int cyc);
    return model(cyc, S_HV, S_HF, S_HS, S_HB, S_VV, S_VF, S_VS, S_VB, 1'b1);
  endfunction

  task automatic check(string tag, logic [25:0] obs, logic [25:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s n=%0d observed H=%0d V=%0d flags=%b expected H=%0d V=%0d flags=%b",
             tag, n, obs[25:16], obs[15:6], obs[5:0], exp[25:16], exp[15:6], exp[5:0]);
    end
  endtask

  task automatic check_int(string tag, int obs, int exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s n=%0d observed=%0d expected=%0d", tag, n, obs, exp);
    end
  endtask

  function automatic logic [25:0] obs_a();
    return {hc_a, vc_a, hs_a, vs_a, vid_a, stb_a, lt_a, ft_a};
  endfunction

  function automatic logic [25:0] obs_b();
    return {hc_b, vc_b, hs_b, vs_b, vid_b, stb_b, lt_b, ft_b};
  endfunction

  task automatic step();
    @(posedge clk);
    n++;
    @(negedge clk);
  endtask

  // Full-size instance: checked at every sync/window boundary, on every expected tick, and at random points.
  task automatic check_step(int full_b_until);
    int ha;
    logic [25:0] ea;
    ea = exp_a(n);
    ha = (n / DIV) % 800;
    if (ha == 0 || ha == 1 || ha == 95 || ha == 96 || ha == 143 || ha == 144 ||
        ha == 783 || ha == 784 || ha == 799 || ea[1] || $urandom_range(0, 15) == 0)
      check("run_a", obs_a(), ea);
    if (n < full_b_until || $urandom_range(0, 7) == 0)
      check("run_b", obs_b(), exp_b(n));
    if (ft_b) begin
      if (last_ft_b >= 0) check_int("frame_period_b", n - last_ft_b, S_FRAME * DIV);
      last_ft_b = n;
    end
  endtask

  initial begin
    n = 0;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_a", obs_a(), exp_a(0));
    check("reset_b", obs_b(), exp_b(0));

    resetn = 1'b1;
    for (int i = 0; i < 29000 * DIV; i++) begin
      step();
      check_step(8 * S_FRAME * DIV);
    end

    // Mid-frame reset: asserted between edges, visible before the next edge.
    repeat ($urandom_range(17, 97)) step();
    @(posedge clk);
    #2 resetn = 1'b0;
    n = 0;
    last_ft_b = -1;
    #1;
    check("async_reset_a", obs_a(), exp_a(0));
    check("async_reset_b", obs_b(), exp_b(0));
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("held_reset_a", obs_a(), exp_a(0));
    check("held_reset_b", obs_b(), exp_b(0));

    resetn = 1'b1;
    for (int i = 0; i < 4 * S_FRAME * DIV + 900 * DIV; i++) begin
      step();
      check_step(4 * S_FRAME * DIV);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
